// File: rtl/softmax_pkt_maxscan.sv
// Packet pass-through stage that forwards logits to the softmax buffer FIFO
// and reports the signed maximum of each completed packet.
module softmax_pkt_maxscan #(
  parameter int DEPTH = 64,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_W-1:0]        cfg_len_i,
  input  logic                    in_valid_i,
  input  logic signed [31:0]      in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic signed [31:0]      out_data_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    max_valid_o,
  output logic signed [31:0]      max_data_o,
  output logic                    busy_o,
  output logic                    err_len_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q;
  logic [LEN_W-1:0]        cnt_q, len_q;
  logic [LEN_W-1:0]        cnt_d, len_d;
  logic signed [31:0]      max_q, max_d;
  logic                    out_valid_q, out_last_q;
  logic signed [31:0]      out_data_q;
  logic                    max_valid_q;
  logic signed [31:0]      max_data_q;
  logic                    accept;
  logic                    last_d;

  // Ties keep the running max, so only a strictly larger logit replaces it.
  function automatic logic signed [31:0] smax(input logic signed [31:0] cur,
                                               input logic signed [31:0] cand);
    return (cand > cur) ? cand : cur;
  endfunction

  assign err_len_o   = (state_q == IDLE) &&
                       ((cfg_len_i == '0) || (cfg_len_i > LEN_W'(DEPTH)));
  assign in_ready_o  = (state_q != DONE) && !err_len_o &&
                       (!out_valid_q || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign max_valid_o = max_valid_q;
  assign max_data_o  = max_data_q;

  always_comb begin
    cnt_d  = (state_q == IDLE) ? LEN_W'(1) : cnt_q + LEN_W'(1);
    len_d  = (state_q == IDLE) ? cfg_len_i : len_q;
    max_d  = (state_q == IDLE) ? in_data_i : smax(max_q, in_data_i);
    last_d = (cnt_d == len_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      max_valid_q <= 1'b0;
      max_data_q  <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data_i;
        out_last_q  <= last_d;
        cnt_q       <= cnt_d;
        len_q       <= len_d;
        max_q       <= max_d;
        state_q     <= last_d ? DONE : RUN;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      // In DONE the register can only hold the packet's final element.
      if ((state_q == DONE) && out_valid_q && out_ready_i)
        state_q <= IDLE;

      max_valid_q <= accept && last_d;
      if (accept && last_d)
        max_data_q <= max_d;
    end
  end

endmodule

// File: tb/tb_softmax_pkt_maxscan.sv
// Scenario bench for softmax_pkt_maxscan: forwarded beats and packet maxima
// are scored against queues filled as stimulus is accepted.
module tb_softmax_pkt_maxscan;

  localparam int DEPTH = 64;
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LEN_W-1:0] cfg_len_i = '0;
  logic             in_valid_i = 1'b0;
  logic [31:0]      in_data_i = '0;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [31:0]      out_data_o;
  logic             out_last_o;
  logic             out_ready_i = 1'b1;
  logic             max_valid_o;
  logic [31:0]      max_data_o;
  logic             busy_o;
  logic             err_len_o;

  int checks = 0;
  int errors = 0;
  int mpulses = 0;

  logic [32:0] exp_q[$];
  logic [31:0] mx_q[$];

  softmax_pkt_maxscan #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_len_i(cfg_len_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .max_valid_o(max_valid_o), .max_data_o(max_data_o),
    .busy_o(busy_o), .err_len_o(err_len_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop on every FIFO transfer and every max pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected data=%h last=%b", out_data_o, out_last_o);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({out_last_o, out_data_o} !== e) begin
            errors++;
            $display("FAIL xfer got last=%b data=%h want last=%b data=%h",
                     out_last_o, out_data_o, e[32], e[31:0]);
          end
        end
      end
      if (max_valid_o) begin
        mpulses++;
        checks++;
        if (mx_q.size() == 0) begin
          errors++;
          $display("FAIL max_unexpected data=%h", max_data_o);
        end else begin
          logic [31:0] m;
          m = mx_q.pop_front();
          if (max_data_o !== m) begin
            errors++;
            $display("FAIL max_data got %h want %h", max_data_o, m);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [31:0] mx,
                      output int rej);
    logic acc;
    acc = 1'b0;
    rej = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    for (int k = 0; k < 40 && !acc; k++) begin
      #1;
      acc = in_ready_o;
      if (acc) begin
        exp_q.push_back({last, d});
        if (last) mx_q.push_back(mx);
      end else begin
        rej++;
      end
      tick();
    end
    in_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout data=%h in_ready=%b want 1", d, in_ready_o);
    end else begin
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== d) begin
        errors++;
        $display("FAIL latency got v=%b data=%h want v=1 data=%h", out_valid_o, out_data_o, d);
      end
      if (last) begin
        checks++;
        if (max_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL max_pulse_timing got %b want 1", max_valid_o);
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && (exp_q.size() != 0 || mx_q.size() != 0 || busy_o); k++)
      tick();
    checks++;
    if (exp_q.size() != 0 || mx_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain got pend=%0d maxpend=%0d busy=%b want 0 0 0",
               exp_q.size(), mx_q.size(), busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_len_i = 4;
    tick();
    tick();
    checks++;
    if ({out_valid_o, out_last_o, max_valid_o, busy_o} !== 4'b0 ||
        out_data_o !== 32'h0 || max_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b l=%b mv=%b busy=%b d=%h m=%h want zeros",
               out_valid_o, out_last_o, max_valid_o, busy_o, out_data_o, max_data_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", in_ready_o);
    end
    tick();
  endtask

  task automatic test_basic();
    int rej;
    int p0;
    p0 = mpulses;
    cfg_len_i = 4;
    out_ready_i = 1'b1;
    send(32'd3, 1'b0, 32'd0, rej);
    send(-32'sd7, 1'b0, 32'd0, rej);
    send(32'd12, 1'b0, 32'd0, rej);
    send(32'd5, 1'b1, 32'd12, rej);
    wait_drain();
    checks++;
    if (mpulses - p0 !== 1) begin
      errors++;
      $display("FAIL basic_pulses got %0d want 1", mpulses - p0);
    end
  endtask

  task automatic test_len1();
    int rej;
    cfg_len_i = 1;
    send(32'h8000_0000, 1'b1, 32'h8000_0000, rej);
    checks++;
    if (busy_o !== 1'b1 || out_last_o !== 1'b1) begin
      errors++;
      $display("FAIL len1_done got busy=%b last=%b want 1 1", busy_o, out_last_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL len1_idle got busy=%b want 0", busy_o);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    int rej;
    cfg_len_i = 3;
    send(32'd10, 1'b0, 32'd0, rej);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'd20;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== 32'd10) begin
        errors++;
        $display("FAIL stall got rdy=%b v=%b data=%h want 0 1 0000000a",
                 in_ready_o, out_valid_o, out_data_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    send(32'd20, 1'b0, 32'd0, rej);
    send(32'd15, 1'b1, 32'd20, rej);
    wait_drain();
  endtask

  task automatic test_err_len();
    cfg_len_i  = 0;
    in_valid_i = 1'b1;
    in_data_i  = 32'd99;
    #1;
    checks++;
    if (err_len_o !== 1'b1 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL err_len0 got err=%b rdy=%b want 1 0", err_len_o, in_ready_o);
    end
    tick();
    tick();
    tick();
    checks++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL err_accepted got busy=%b v=%b want 0 0", busy_o, out_valid_o);
    end
    cfg_len_i = 65;
    #1;
    checks++;
    if (err_len_o !== 1'b1 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL err_len65 got err=%b rdy=%b want 1 0", err_len_o, in_ready_o);
    end
    in_valid_i = 1'b0;
    cfg_len_i  = 64;
    #1;
    checks++;
    if (err_len_o !== 1'b0) begin
      errors++;
      $display("FAIL err_len64 got %b want 0", err_len_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int rej;
    int p0;
    cfg_len_i = 4;
    send(32'd50, 1'b0, 32'd0, rej);
    send(32'd60, 1'b0, 32'd0, rej);
    p0 = mpulses;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({out_valid_o, out_last_o, max_valid_o, busy_o} !== 4'b0 ||
        out_data_o !== 32'h0 || max_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%b l=%b mv=%b busy=%b d=%h m=%h want zeros",
               out_valid_o, out_last_o, max_valid_o, busy_o, out_data_o, max_data_o);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (mpulses != p0) begin
      errors++;
      $display("FAIL reset_mid_pulse got %0d want 0", mpulses - p0);
    end
    cfg_len_i = 2;
    send(-32'sd5, 1'b0, 32'd0, rej);
    send(-32'sd2, 1'b1, -32'sd2, rej);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int rej;
    cfg_len_i = 2;
    send(32'hFFFF_FFFF, 1'b0, 32'd0, rej);
    cfg_len_i = 0;
    #1;
    checks++;
    if (err_len_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL run_cfg_change got err=%b rdy=%b want 0 1", err_len_o, in_ready_o);
    end
    tick();
    send(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, rej);
    cfg_len_i = 2;
    send(32'h7FFF_FFFF, 1'b0, 32'd0, rej);
    checks++;
    if (rej != 1) begin
      errors++;
      $display("FAIL done_gap got %0d want 1", rej);
    end
    send(32'h0, 1'b1, 32'h7FFF_FFFF, rej);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len1();
    test_stall();
    test_err_len();
    test_reset_mid();
    test_back_to_back();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/softmax_pkt_maxscan.md
SOFTMAX_PKT_MAXSCAN -- requirements
Module: softmax_pkt_maxscan

Interface
REQ-001 SHALL have parameter DEPTH, default 64, setting the maximum packet length; it SHALL match the downstream FIFO depth.
REQ-002 SHALL have parameter LEN_W, default $clog2(DEPTH)+1, setting the width of the length field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cfg_len_i, input, LEN_W bits: packet length in elements, sampled at the first beat of each packet.
REQ-006 SHALL have port in_valid_i, input, 1 bit: upstream logit valid.
REQ-007 SHALL have port in_data_i, input, 32 bits: signed two's-complement logit.
REQ-008 SHALL have port in_ready_o, output, 1 bit: the block accepts a logit.
REQ-009 SHALL have port out_valid_o, output, 1 bit: a logit is offered to the buffer FIFO s_valid_i.
REQ-010 SHALL have port out_data_o, output, 32 bits: forwarded logit, to the FIFO s_data_i.
REQ-011 SHALL have port out_last_o, output, 1 bit: final element of the packet, to the FIFO s_last_i.
REQ-012 SHALL have port out_ready_i, input, 1 bit: from the FIFO s_ready_o.
REQ-013 SHALL have port max_valid_o, output, 1 bit: a one-cycle pulse marking max_data_o as valid.
REQ-014 SHALL have port max_data_o, output, 32 bits: signed maximum of the completed packet.
REQ-015 SHALL have port busy_o, output, 1 bit: high when the state is not IDLE.
REQ-016 SHALL have port err_len_o, output, 1 bit: in IDLE, cfg_len_i is 0 or greater than DEPTH.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 SHALL hold a one-entry output register (out_valid_o, out_data_o, out_last_o); a transfer occurs when out_valid_o and out_ready_i are both 1.
REQ-019 in_ready_o SHALL equal (state != DONE) && !err_len_o && (!out_valid_o || out_ready_i).
REQ-020 An input beat SHALL be accepted when in_valid_i && in_ready_o; the beat SHALL appear on out_data_o in the next cycle (1-cycle latency) with data unchanged.
REQ-021 In IDLE, an accepted beat SHALL:
- latch cfg_len_i as len_q;
- set cnt to 1;
- set max_q to in_data_i;
- move to RUN, or to DONE if len_q == 1.
REQ-022 In RUN, an accepted beat SHALL:
- increment cnt;
- set max_q to the larger of max_q and in_data_i (signed 32-bit compare);
- move to DONE when the beat is number len_q.
REQ-023 out_last_o SHALL be 1 only with the element whose index equals len_q.
REQ-024 On the cycle the last beat is accepted, max_valid_o SHALL pulse exactly one cycle later, with max_data_o equal to the final max, including that last beat.
REQ-025 max_data_o SHALL hold its value until the next packet completes.
REQ-026 DONE SHALL keep in_ready_o at 0 until the last element has transferred to the FIFO, then return to IDLE in the next cycle.
REQ-027 If out_valid_o is 1 and out_ready_i is 0, out_data_o and out_last_o SHALL stay stable.
REQ-028 A simultaneous output transfer and input accept SHALL replace the register contents with no bubble.
REQ-029 A change of cfg_len_i in RUN or DONE SHALL have no effect.
REQ-030 err_len_o SHALL be combinational and asserted only in IDLE.
REQ-031 cnt SHALL be LEN_W bits wide and SHALL never exceed DEPTH.
REQ-032 Signed compare edge cases SHALL hold: 0x80000000 SHALL be the minimum and 0x7FFFFFFF the maximum; equal values SHALL keep max_q.

Reset
REQ-033 While rst is 1, and asynchronously on its assertion, the block SHALL set:
- state = IDLE;
- cnt = 0, len_q = 0, max_q = 0;
- out_valid_o = 0, out_last_o = 0, out_data_o = 0;
- max_valid_o = 0, max_data_o = 0.
REQ-034 Reset asserted mid-packet SHALL discard the partial packet, and no max_valid_o pulse SHALL be generated for it.
REQ-035 After rst is released, in_ready_o SHALL be 1 in the first cycle, provided cfg_len_i is valid.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- cfg_len_i=4, inputs {3, -7, 12, 5}, out_ready_i always 1 -> outputs same order one cycle later; out_last_o only on 5; max_valid_o one pulse; max_data_o=12.
- cfg_len_i=1, input 0x80000000 -> out_last_o=1 on that element; max_data_o=0x80000000; state returns to IDLE after the transfer.
- cfg_len_i=3, out_ready_i low for 5 cycles mid-packet -> out_data_o stable; in_ready_o=0 while the register is full; no data lost or duplicated; max_data_o correct.
- cfg_len_i=0, then 65 (DEPTH=64) -> err_len_o=1, in_ready_o=0, no beats accepted.
- rst pulsed after 2 of 4 beats -> all outputs return to reset values; no max_valid_o pulse; next packet of 2 gives the correct max.
- Back-to-back packets of len 2: {-1, -1} then {0x7FFFFFFF, 0} -> max_data_o -1, then 0x7FFFFFFF; one DONE gap between packets; cfg_len_i changed during RUN is ignored.
